// File: rtl/wb_arb_pkg.sv
// Shared types and widths for the 4-master Wishbone round-robin arbiter.
package wb_arb_pkg;
  localparam int MASTER_COUNT = 4;
  localparam int GRANT_W      = 2;
  localparam int SEL_W        = 4;
  localparam int ADR_W        = 32;
  localparam int DAT_W        = 32;
  localparam int CNT_W        = 16;
  localparam int DEAD_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DEAD  = 2'd2
  } arb_state_e;

  // One master's request lane as seen by the slave-side mux.
  typedef struct packed {
    logic             cyc;
    logic             stb;
    logic             we;
    logic [SEL_W-1:0] sel;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } wb_req_t;
endpackage

// File: rtl/rr_picker_4.sv
// Combinational round-robin pick: first requester above 'last', wrapping mod 4.
module rr_picker_4
  import wb_arb_pkg::*;
(
  input  logic [MASTER_COUNT-1:0] req,
  input  logic [GRANT_W-1:0]      last,
  output logic [GRANT_W-1:0]      grant,
  output logic                    any
);
  logic [GRANT_W-1:0] idx;

  // Walk from lowest priority (last itself) to highest (last+1); the final hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = MASTER_COUNT; k >= 1; k--) begin
      idx = last + GRANT_W'(k);
      if (req[idx]) grant = idx;
    end
  end

  assign any = |req;
endmodule

// File: rtl/wb_rr_arbiter_4.sv
// Four-master Wishbone round-robin arbiter with stall timeout and dead cycles
// between grants.
module wb_rr_arbiter_4
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT     = 1024,
  parameter int DEAD_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MASTER_COUNT-1:0]       m_cyc_i,
  input  logic [MASTER_COUNT-1:0]       m_stb_i,
  input  logic [MASTER_COUNT-1:0]       m_we_i,
  input  logic [MASTER_COUNT*SEL_W-1:0] m_sel_i,
  input  logic [MASTER_COUNT*ADR_W-1:0] m_adr_i,
  input  logic [MASTER_COUNT*DAT_W-1:0] m_dat_i,
  output logic [DAT_W-1:0]              m_dat_o,
  output logic [MASTER_COUNT-1:0]       m_ack_o,
  output logic [MASTER_COUNT-1:0]       m_err_o,
  output logic [MASTER_COUNT-1:0]       m_int_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic                          s_we_o,
  output logic [SEL_W-1:0]              s_sel_o,
  output logic [ADR_W-1:0]              s_adr_o,
  output logic [DAT_W-1:0]              s_dat_o,
  input  logic                          s_ack_i,
  input  logic                          s_int_i,
  input  logic [DAT_W-1:0]              s_dat_i,
  output logic [GRANT_W-1:0]            grant_o,
  output logic                          grant_valid_o
);
  arb_state_e                       state, state_nx;
  logic [GRANT_W-1:0]               grant, last_grant, pick;
  logic                             any_req;
  logic [CNT_W-1:0]                 stall_cnt;
  logic [DEAD_W-1:0]                dead_cnt;
  logic                             active, stall, timeout, done;
  wb_req_t [MASTER_COUNT-1:0]       req;
  wb_req_t                          sel_req;

  rr_picker_4 u_picker (
    .req   (m_cyc_i),
    .last  (last_grant),
    .grant (pick),
    .any   (any_req)
  );

  assign active = (state == ST_GRANT);

  for (genvar n = 0; n < MASTER_COUNT; n++) begin : g_lane
    assign req[n] = '{cyc: m_cyc_i[n],
                      stb: m_stb_i[n],
                      we:  m_we_i[n],
                      sel: m_sel_i[n*SEL_W +: SEL_W],
                      adr: m_adr_i[n*ADR_W +: ADR_W],
                      dat: m_dat_i[n*DAT_W +: DAT_W]};
    assign m_ack_o[n] = active  && (grant == GRANT_W'(n)) && s_ack_i;
    assign m_int_o[n] = active  && (grant == GRANT_W'(n)) && s_int_i;
    assign m_err_o[n] = timeout && (grant == GRANT_W'(n));
  end

  assign sel_req = active ? req[grant] : '0;
  assign s_cyc_o = sel_req.cyc;
  assign s_stb_o = sel_req.stb;
  assign s_we_o  = sel_req.we;
  assign s_sel_o = sel_req.sel;
  assign s_adr_o = sel_req.adr;
  assign s_dat_o = sel_req.dat;
  assign m_dat_o = s_dat_i;

  assign grant_o       = grant;
  assign grant_valid_o = active;

  // An ack always beats the timeout; a cycle ending on its ack cycle closes one cycle later.
  assign stall   = active && sel_req.stb && !s_ack_i;
  assign timeout = stall && (stall_cnt == CNT_W'(TIMEOUT - 1));
  assign done    = active && !sel_req.cyc && !s_ack_i;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (any_req) state_nx = ST_GRANT;
      ST_GRANT: if (timeout || done) state_nx = ST_DEAD;
      ST_DEAD:  if (dead_cnt == DEAD_W'(DEAD_CYCLES - 1)) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= GRANT_W'(MASTER_COUNT - 1);
      stall_cnt  <= '0;
      dead_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && any_req) grant <= pick;
      if (active && state_nx == ST_DEAD) last_grant <= grant;
      stall_cnt <= (stall && state_nx == ST_GRANT) ? stall_cnt + 1'b1 : '0;
      dead_cnt  <= (state == ST_DEAD) ? dead_cnt + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_wb_rr_arbiter_4.sv
// Randomized scoreboard bench for wb_rr_arbiter_4 against a behavioural
// round-robin/timeout model.
module tb_wb_rr_arbiter_4;
  localparam int TO   = 8;
  localparam int DC   = 2;
  localparam int NCYC = 3000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       cyc_v = '0, stb_v = '0, we_v = '0;
  logic [3:0][3:0]  sel_v = '0;
  logic [3:0][31:0] adr_v = '0, dat_v = '0;
  logic             s_ack = 1'b0, s_int = 1'b0;
  logic [31:0]      s_rdat = '0;

  logic [31:0] m_dat_o;
  logic [3:0]  m_ack_o, m_err_o, m_int_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [1:0]  grant_o;
  logic        grant_valid_o;

  wb_rr_arbiter_4 #(.TIMEOUT(TO), .DEAD_CYCLES(DC)) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(cyc_v), .m_stb_i(stb_v), .m_we_i(we_v),
    .m_sel_i(sel_v), .m_adr_i(adr_v), .m_dat_i(dat_v),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_int_o(m_int_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack), .s_int_i(s_int), .s_dat_i(s_rdat),
    .grant_o(grant_o), .grant_valid_o(grant_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        gv;
    logic [1:0]  g;
    logic [70:0] bus;
    logic [11:0] resp;
    logic [31:0] rdat;
  } exp_t;

  exp_t q[$];
  int   errors = 0, checks = 0;
  bit   finished = 0;

  // Reference model: mode 0 idle, 1 owner holds the bus, 2 gap between grants.
  int mode = 0, owner = 0, last = 3, stall = 0, gap = 0, smode = 0;
  bit active[4], acked[4], errd[4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp, input int t);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  task automatic model_step(input bit to_hit);
    bit found;
    int r;
    found = 0;
    case (mode)
      0: if (|cyc_v) begin
           for (int k = 1; k <= 4; k++)
             if (!found && cyc_v[(last + k) % 4]) begin owner = (last + k) % 4; found = 1; end
           mode  = 1;
           stall = 0;
           r     = $urandom % 6;
           smode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
         end
      1: if (to_hit || (!cyc_v[owner] && !s_ack)) begin
           last = owner; mode = 2; gap = DC; stall = 0;
         end else if (stb_v[owner] && !s_ack) stall++;
         else stall = 0;
      default: begin gap--; if (gap == 0) mode = 0; end
    endcase
  endtask

  task automatic do_cycle(input bit rst_now);
    exp_t       e;
    int         o;
    bit         to_hit;
    logic [3:0] ackv, errv, intv;
    @(negedge clk);
    rst = rst_now;
    if (rst_now) begin mode = 0; last = 3; stall = 0; gap = 0; end
    for (int n = 0; n < 4; n++) begin
      if (errd[n]) begin active[n] = 0; errd[n] = 0; end
      else if (acked[n]) begin acked[n] = 0; if ($urandom % 2 == 1) active[n] = 0; end
      else if (!active[n] && $urandom % 4 == 0) active[n] = 1;
      cyc_v[n] = active[n];
      stb_v[n] = active[n] && ($urandom % 8 != 0);
      we_v[n]  = 1'($urandom);
      sel_v[n] = 4'($urandom);
      adr_v[n] = $urandom;
      dat_v[n] = $urandom;
    end
    s_int  = 1'($urandom);
    s_rdat = $urandom;
    s_ack  = 1'b0;
    o      = owner;
    if (mode == 1) begin
      case (smode)
        0:       s_ack = stb_v[o] && ($urandom % 3 == 0);
        1:       s_ack = 1'b0;
        default: s_ack = stb_v[o] && (stall == TO - 1);
      endcase
      // Master sometimes drops cyc on the very cycle its ack arrives.
      if (s_ack && $urandom % 3 == 0) begin cyc_v[o] = 1'b0; active[o] = 0; end
    end
    to_hit = (mode == 1) && stb_v[o] && !s_ack && (stall == TO - 1);
    ackv = '0; errv = '0; intv = '0;
    e.rst  = rst_now;
    e.gv   = (mode == 1);
    e.g    = 2'(o);
    e.rdat = s_rdat;
    e.bus  = '0;
    if (mode == 1) begin
      e.bus   = {cyc_v[o], stb_v[o], we_v[o], sel_v[o], adr_v[o], dat_v[o]};
      ackv[o] = s_ack;
      errv[o] = to_hit;
      intv[o] = s_int;
      if (s_ack && active[o]) acked[o] = 1;
      if (to_hit) errd[o] = 1;
    end
    e.resp = {ackv, errv, intv};
    q.push_back(e);
    @(posedge clk);
    if (!rst_now) model_step(to_hit);
  endtask

  initial begin
    exp_t e;
    int   t;
    t = 0;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() == 0) begin
        if (finished) break;
        checks++;
        errors++;
        $display("FAIL sb_empty cycle %0d: got no expected entry, required one", t);
      end else begin
        e = q.pop_front();
        chk("bus", 128'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o}), 128'(e.bus), t);
        chk("ack_err_int", 128'({m_ack_o, m_err_o, m_int_o}), 128'(e.resp), t);
        chk("rdat", 128'(m_dat_o), 128'(e.rdat), t);
        chk("grant_valid", 128'(grant_valid_o), 128'(e.gv), t);
        if (e.gv)  chk("grant", 128'(grant_o), 128'(e.g), t);
        if (e.rst) chk("grant_reset", 128'(grant_o), 128'(0), t);
      end
      t++;
    end
  end

  initial begin
    bit did_rst;
    did_rst = 0;
    for (int n = 0; n < 4; n++) begin active[n] = 0; acked[n] = 0; errd[n] = 0; end
    repeat (3) do_cycle(1'b1);
    for (int i = 0; i < NCYC; i++) begin
      // Reset dropped into a live grant, preferably while master 1 owns the bus.
      if (!did_rst && i >= 1200 && mode == 1 && (owner == 1 || i >= 1500)) begin
        do_cycle(1'b1);
        did_rst = 1;
      end else do_cycle(1'b0);
    end
    finished = 1;
    @(negedge clk);
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish, errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end
endmodule
